wb_ram_slave: RTL and testbench

- Word-addressed Wishbone classic-cycle RAM slave. Sits directly downstream of the Wishbone test master and terminates its STB/CYC cycles.
- Stores written words and returns them on reads, after a programmable number of wait states.
- Terminates each cycle with exactly one of ACK, ERR or RTY.
- Used as the target for master write/read-back checks.

---
 rtl/wb_ram_slave.sv | 172 +++++++++++++++++
 tb/tb_wb_ram_slave.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/wb_ram_slave.sv
// wb_ram_slave -- word-addressed Wishbone classic-cycle RAM slave.
//
// Terminates each STB/CYC cycle from the master with exactly one of ACK or
// ERR after WAIT_STATES extra cycles. Writes store DAT_I and reads return the
// stored word on DAT_O, which holds until the next completed read. RTY is
// never raised.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   BASE_ADDR    first word address decoded by the slave
//   WAIT_STATES  extra cycles between request sample and response (0..15)
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   STB, CYC        strobe / bus cycle valid from master
//   ADR, DAT_I      word address, write data
//   CTI_I, WE       cycle type (000/111 supported), write enable
//   DAT_O           registered read data
//   ACK, ERR, RTY   registered terminations (RTY tied low)
//
// Build option:
//   WB_RAM_RANGE_CHECK_EN  when defined, addresses outside
//                          BASE_ADDR..BASE_ADDR+DEPTH_WORDS-1 terminate with
//                          ERR; otherwise they alias into the RAM and get ACK.
module wb_ram_slave #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        STB,
    input  logic        CYC,
    input  logic [31:0] ADR,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    input  logic [2:0]  CTI_I,
    input  logic        WE,
    output logic        ACK,
    output logic        ERR,
    output logic        RTY
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        fire;

    logic [31:0] adr_q, wdat_q;
    logic [2:0]  cti_q;
    logic        we_q;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] dato_q;
    logic        ack_q, err_q;

    // In IDLE the request fields come straight off the bus so a zero-wait
    // response can complete on the very edge the request is sampled.
    logic        in_idle;
    logic [31:0] req_adr, req_dat, offset;
    logic [2:0]  req_cti;
    logic        req_we, cti_ok, range_ok, req_err;
    logic [AW-1:0] req_idx;

    assign in_idle = (state == S_IDLE);
    assign req_adr = in_idle ? ADR   : adr_q;
    assign req_dat = in_idle ? DAT_I : wdat_q;
    assign req_cti = in_idle ? CTI_I : cti_q;
    assign req_we  = in_idle ? WE    : we_q;

    assign offset  = req_adr - BASE_ADDR;
    assign req_idx = offset[AW-1:0];
    assign cti_ok  = (req_cti == 3'b000) || (req_cti == 3'b111);

`ifdef WB_RAM_RANGE_CHECK_EN
    assign range_ok = (offset < DEPTH_WORDS);
`else
    // Upper offset bits only matter to the range check; here they alias.
    logic unused_hi;
    assign unused_hi = ^offset[31:AW];
    assign range_ok  = 1'b1;
`endif

    assign req_err = !cti_ok || !range_ok;

    // Next-state logic; fire marks the edge on which the termination rises.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        fire    = 1'b0;
        case (state)
            S_IDLE: begin
                if (STB && CYC) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                        fire    = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!(STB && CYC)) begin
                    state_d = S_IDLE;        // master gave up: silent abort
                end else if (cnt == 4'd0) begin
                    state_d = S_RESP;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            adr_q  <= 32'd0;
            wdat_q <= 32'd0;
            cti_q  <= 3'd0;
            we_q   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (in_idle && STB && CYC) begin
                adr_q  <= ADR;
                wdat_q <= DAT_I;
                cti_q  <= CTI_I;
                we_q   <= WE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            dato_q <= 32'd0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (fire) begin
                if (req_err) begin
                    err_q <= 1'b1;
                end else begin
                    ack_q <= 1'b1;
                    if (!req_we) dato_q <= mem[req_idx];
                end
            end
        end
    end

    // RAM is not reset; the rst term drops a write that lands while reset
    // is held.
    always_ff @(posedge clk) begin
        if (rst && fire && !req_err && req_we) mem[req_idx] <= req_dat;
    end

    assign ACK   = ack_q;
    assign ERR   = err_q;
    assign RTY   = 1'b0;
    assign DAT_O = dato_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
module tb_wb_ram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [31:0] adr = 32'd0, dati = 32'd0;
    logic [2:0]  cti = 3'd0;
    int          sel = 0;

    logic [1:0]  ack, err, rty;
    logic [31:0] dato [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instance 0: WAIT_STATES = 1, instance 1: WAIT_STATES = 3.
    // Only the selected instance sees STB/CYC.
    wb_ram_slave #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst), .STB(stb && sel == 0), .CYC(cyc && sel == 0),
        .ADR(adr), .DAT_I(dati), .DAT_O(dato[0]), .CTI_I(cti), .WE(we),
        .ACK(ack[0]), .ERR(err[0]), .RTY(rty[0])
    );

    wb_ram_slave #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .STB(stb && sel == 1), .CYC(cyc && sel == 1),
        .ADR(adr), .DAT_I(dati), .DAT_O(dato[1]), .CTI_I(cti), .WE(we),
        .ACK(ack[1]), .ERR(err[1]), .RTY(rty[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One master cycle, entered and left at a falling edge. lat counts rising
    // edges from the request edge (inclusive) to the termination edge.
    task automatic xfer(input int s, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] c,
                        output int lat, output logic g_ack, output logic g_err,
                        output logic g_rty, output logic [31:0] rd,
                        output logic one_cyc);
        logic done;
        sel = s; we = w; adr = a; dati = d; cti = c; stb = 1'b1; cyc = 1'b1;
        lat = 0; done = 1'b0;
        while (!done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ack[s] || err[s] || rty[s]) done = 1'b1;
        end
        g_ack = ack[s]; g_err = err[s]; g_rty = rty[s]; rd = dato[s];
        stb = 1'b0; cyc = 1'b0;
        @(negedge clk);
        one_cyc = !(ack[s] || err[s] || rty[s]);
    endtask

    int          lat;
    logic        ga, ge, gr, oc;
    logic [31:0] rd;

    initial begin
        // 1. Reset held with the bus requesting
        sel = 0; stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'd1; dati = 32'h11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ack", {31'd0, ack[0]}, 32'd0);
            chk("rst_err_rty", {30'd0, err[0], rty[0]}, 32'd0);
            chk("rst_dato", dato[0], 32'd0);
        end
        rst = 1'b1;
        xfer(0, 1'b1, 32'd1, 32'h11, 3'b000, lat, ga, ge, gr, rd, oc);
        chk("first_lat", lat, 32'd2);
        chk("first_ack", {31'd0, ga}, 32'd1);

        // 2. WAIT_STATES = 1 write/read of address 5
        xfer(0, 1'b1, 32'd5, 32'd5, 3'b000, lat, ga, ge, gr, rd, oc);
        chk("w5_lat", lat, 32'd2);
        chk("w5_ack", {31'd0, ga}, 32'd1);
        chk("w5_onecyc", {31'd0, oc}, 32'd1);
        chk("w5_dato_hold", rd, 32'd0);
        xfer(0, 1'b0, 32'd5, 32'd0, 3'b111, lat, ga, ge, gr, rd, oc);
        chk("r5_lat", lat, 32'd2);
        chk("r5_ack", {31'd0, ga}, 32'd1);
        chk("r5_onecyc", {31'd0, oc}, 32'd1);
        chk("r5_data", rd, 32'h5);

        // 3. Fill every word with its own address, then read all back
        for (int i = 0; i < 256; i++) begin
            xfer(0, 1'b1, 32'(i), 32'(i), 3'b000, lat, ga, ge, gr, rd, oc);
            chk("fill_ack", {29'd0, ga, ge, gr}, 32'h4);
        end
        for (int i = 0; i < 256; i++) begin
            xfer(0, 1'b0, 32'(i), 32'd0, 3'b000, lat, ga, ge, gr, rd, oc);
            chk("rb_term", {29'd0, ga, ge, gr}, 32'h4);
            chk("rb_data", rd, 32'(i));
        end

        // 4. WAIT_STATES = 3: full write, then an aborted write
        xfer(1, 1'b1, 32'd7, 32'h77, 3'b000, lat, ga, ge, gr, rd, oc);
        chk("ws3_lat", lat, 32'd4);
        chk("ws3_ack", {31'd0, ga}, 32'd1);
        chk("ws3_onecyc", {31'd0, oc}, 32'd1);
        sel = 1; we = 1'b1; adr = 32'd7; dati = 32'hDEAD; cti = 3'b000;
        stb = 1'b1; cyc = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_quiet", {30'd0, ack[1], err[1]}, 32'd0);
        end
        xfer(1, 1'b0, 32'd7, 32'd0, 3'b000, lat, ga, ge, gr, rd, oc);
        chk("abort_rb", rd, 32'h77);

        // Reset in the middle of a write: immediate clear, write dropped
        sel = 1; we = 1'b1; adr = 32'd7; dati = 32'hBEEF; stb = 1'b1; cyc = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("midrst_dato", dato[1], 32'd0);
        chk("midrst_term", {30'd0, ack[1], err[1]}, 32'd0);
        stb = 1'b0; cyc = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        xfer(1, 1'b0, 32'd7, 32'd0, 3'b000, lat, ga, ge, gr, rd, oc);
        chk("midrst_rb", rd, 32'h77);

        // 5. Unsupported cycle type
        xfer(0, 1'b1, 32'd9, 32'hBAD, 3'b010, lat, ga, ge, gr, rd, oc);
        chk("cti_term", {29'd0, ga, ge, gr}, 32'h2);
        chk("cti_lat", lat, 32'd2);
        chk("cti_onecyc", {31'd0, oc}, 32'd1);
        xfer(0, 1'b0, 32'd9, 32'd0, 3'b000, lat, ga, ge, gr, rd, oc);
        chk("cti_rb", rd, 32'd9);

        // 6. Address one past the end
        xfer(0, 1'b1, 32'd256, 32'hA5, 3'b000, lat, ga, ge, gr, rd, oc);
`ifdef WB_RAM_RANGE_CHECK_EN
        chk("oor_term", {29'd0, ga, ge, gr}, 32'h2);
        xfer(0, 1'b0, 32'd0, 32'd0, 3'b000, lat, ga, ge, gr, rd, oc);
        chk("oor_rb0", rd, 32'd0);
`else
        chk("oor_term", {29'd0, ga, ge, gr}, 32'h4);
        xfer(0, 1'b0, 32'd0, 32'd0, 3'b000, lat, ga, ge, gr, rd, oc);
        chk("oor_rb0", rd, 32'hA5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
